// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_pkg
//  Description : Shared types and helpers for the LED sequencing controller.
//                LED_W      - width of the LED register
//                INIT_PAT   - default power-on / post-release pattern
//                led_state_e- controller states (RUN, FORCE)
//                rotate()   - one-position rotate, 0 = right, 1 = left
//  Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    localparam int LED_W = 6;

    localparam logic [LED_W-1:0] INIT_PAT = 6'b011111;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FORCE = 1'b1
    } led_state_e;

    // left = 0 : {v[0], v[W-1:1]}   (bit 0 wraps to the top)
    // left = 1 : {v[W-2:0], v[W-1]} (top bit wraps to bit 0)
    function automatic logic [LED_W-1:0] rotate(input logic [LED_W-1:0] v,
                                                input logic             left);
        return left ? {v[LED_W-2:0], v[LED_W-1]} : {v[0], v[LED_W-1:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : led_debounce
//  Description : Two-flop synchronizer plus stability counter for the raw
//                active-low set button. set_act follows the synchronized
//                button (1 = pressed) once that level has differed from the
//                current set_act for DEB_CYCLES consecutive cycles.
//  Ports       : clk450MHz  in  clock
//                sys_rst_n  in  async active-low reset
//                sys_set_n  in  raw asynchronous button, active-low
//                set_act    out registered debounced "button pressed"
//  Revision    : 1.0 - initial release
// ============================================================================
module led_debounce #(
    parameter int DEB_CYCLES = 65_536
) (
    input  logic clk450MHz,
    input  logic sys_rst_n,
    input  logic sys_set_n,
    output logic set_act
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] cnt;

    // Synchronizer flops reset to the released (high) level so a reset does
    // not look like a press.
    always_ff @(posedge clk450MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_a  <= 1'b1;
            sync_b  <= 1'b1;
            cnt     <= '0;
            set_act <= 1'b0;
        end else begin
            sync_a <= sys_set_n;
            sync_b <= sync_a;
            // Count only while the synchronized level disagrees with the
            // accepted one; any return to agreement restarts the count.
            if ((~sync_b) != set_act) begin
                if (cnt == CNT_MAX) begin
                    set_act <= ~sync_b;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : led_seq_ctrl
//  Description : LED sequencing controller. A free-running prescaler makes a
//                clock-enable (ce_tick); a step timer counts ce_ticks and
//                requests a rotate every PERIOD_TICKS. A two-state FSM
//                arbitrates the LED register: debounced set button (forces
//                all LEDs off) > valid/ready load > rotate step.
//  Ports       : clk450MHz  in  sole clock
//                sys_rst_n  in  async active-low reset
//                sys_set_n  in  raw button, active-low
//                dir        in  rotate direction, 0 = right, 1 = left
//                ld_valid   in  load request
//                ld_data    in  pattern to load
//                ld_ready   out load accepted when ld_valid & ld_ready
//                led        out registered LED pattern
//                ce_tick    out registered prescaler strobe
//                step_pulse out registered, high when led shows a new rotate
//  Revision    : 1.0 - initial release
// ============================================================================
module led_seq_ctrl
    import led_pkg::*;
#(
    parameter int               DIV          = 10,
    parameter int               PERIOD_TICKS = 22_500_000,
    parameter int               DEB_CYCLES   = 65_536,
    parameter logic [LED_W-1:0] INIT_PAT     = led_pkg::INIT_PAT
) (
    input  logic             clk450MHz,
    input  logic             sys_rst_n,
    input  logic             sys_set_n,
    input  logic             dir,
    input  logic             ld_valid,
    input  logic [LED_W-1:0] ld_data,
    output logic             ld_ready,
    output logic [LED_W-1:0] led,
    output logic             ce_tick,
    output logic             step_pulse
);

    localparam int PW = (DIV > 1)          ? $clog2(DIV)          : 1;
    localparam int SW = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(DIV - 1);
    localparam logic [SW-1:0] SCNT_MAX = SW'(PERIOD_TICKS - 1);

    logic             set_act;
    logic             rst_done;
    logic [PW-1:0]    pcnt;
    logic [SW-1:0]    scnt;
    logic [SW-1:0]    scnt_nxt;
    logic [SW-1:0]    scnt_adv;
    logic             step_req;
    logic             step_nxt;
    logic [LED_W-1:0] led_nxt;
    led_state_e       state;
    led_state_e       state_nxt;

    led_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk450MHz (clk450MHz),
        .sys_rst_n (sys_rst_n),
        .sys_set_n (sys_set_n),
        .set_act   (set_act)
    );

    // Prescaler: free-running in every state, only sys_rst_n clears it.
    always_ff @(posedge clk450MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pcnt    <= '0;
            ce_tick <= 1'b0;
        end else begin
            pcnt    <= (pcnt == PCNT_MAX) ? '0 : pcnt + 1'b1;
            ce_tick <= (pcnt == PCNT_MAX);
        end
    end

    // rst_done keeps ld_ready low for the first clock after reset release.
    always_ff @(posedge clk450MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    assign ld_ready = (state == RUN) & ~set_act & rst_done;
    assign step_req = ce_tick & (scnt == SCNT_MAX);
    assign scnt_adv = ce_tick ? ((scnt == SCNT_MAX) ? '0 : scnt + 1'b1) : scnt;

    always_ff @(posedge clk450MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= RUN;
            led        <= INIT_PAT;
            scnt       <= '0;
            step_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            led        <= led_nxt;
            scnt       <= scnt_nxt;
            step_pulse <= step_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        led_nxt   = led;
        scnt_nxt  = scnt_adv;
        step_nxt  = 1'b0;
        case (state)
            RUN: begin
                if (set_act) begin
                    state_nxt = FORCE;
                    led_nxt   = '0;
                    scnt_nxt  = '0;
                end else if (ld_valid && ld_ready) begin
                    // A load restarts the step period; a coincident step is
                    // dropped rather than deferred.
                    led_nxt  = ld_data;
                    scnt_nxt = '0;
                end else if (step_req) begin
                    led_nxt  = rotate(led, dir);
                    step_nxt = 1'b1;
                end
            end
            FORCE: begin
                led_nxt  = '0;
                scnt_nxt = '0;
                if (!set_act) begin
                    state_nxt = RUN;
                    led_nxt   = INIT_PAT;
                end
            end
            default: begin
                state_nxt = RUN;
                led_nxt   = INIT_PAT;
                scnt_nxt  = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

LED sequencing controller in the 450 MHz domain. Generates a clock-enable from clk450MHz instead of a fabric-derived clock. Schedules rotate steps of the 6-bit LED pattern and arbitrates access to the LED register between three requesters: the debounced set button, a load port with a valid/ready handshake, and the periodic rotate timer. Sits between the rPLL output and the board LED pins.

## Interface
Parameters:
- DIV, 10: prescaler ratio; ce_tick fires once every DIV clk450MHz cycles (≥2).
- PERIOD_TICKS, 22_500_000: ce_ticks per rotate step (0.5 s at defaults); ≥1.
- DEB_CYCLES, 65_536: cycles the synchronized button level must stay stable before it is accepted.
- INIT_PAT, 6'b011111: LED pattern at reset and after button release.

Ports:
- clk450MHz  in  1  sole clock.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- sys_set_n  in  1  raw asynchronous button, active-low (force all LEDs off).
- dir  in  1  rotate direction: 0 = right ({led[0],led[5:1]}), 1 = left ({led[4:0],led[5]}); sampled at step.
- ld_valid  in  1  load request.
- ld_data  in  6  pattern to load.
- ld_ready  out  1  load accepted when ld_valid & ld_ready.
- led  out  6  registered LED pattern.
- ce_tick  out  1  registered one-cycle prescaler strobe.
- step_pulse  out  1  registered; high in the cycle led shows a new rotated value.

## Operation
- Button path: 2-FF synchronizer, then debouncer; set_act (registered) goes 1 after sync'd low stable DEB_CYCLES, 0 after sync'd high stable DEB_CYCLES. Any bounce restarts the stability count.
- Prescaler: pcnt 0..DIV-1, wraps; ce_tick registered high for the cycle after pcnt==DIV-1.
- Step timer: scnt 0..PERIOD_TICKS-1, advances on ce_tick; step_req when ce_tick & scnt==PERIOD_TICKS-1; scnt wraps to 0.
- FSM states: RUN, FORCE.
  - RUN → FORCE when set_act=1: led ← 000000, scnt ← 0.
  - FORCE: led held 000000, scnt held 0, steps and loads refused.
  - FORCE → RUN when set_act=0: led ← INIT_PAT, scnt ← 0.
- ld_ready = (state==RUN) & ~set_act & rst_done (rst_done: flop, 0 in reset, 1 from first clock after reset release). Combinational from flops only.
- Priority in RUN per cycle: set_act > load handshake > step_req.
  - Load: led ← ld_data, scnt ← 0, any coincident step_req dropped (no step_pulse).
  - Step: led ← rotate(led, dir), step_pulse=1.
- Prescaler free-runs in all states; never reset except by sys_rst_n.

## Timing
- Reset values: led=INIT_PAT, ld_ready=0, ce_tick=0, step_pulse=0, state=RUN, pcnt=scnt=0, set_act=0, debounce counter 0.
- First ce_tick DIV cycles after the first active clock edge; then period exactly DIV.
- First step: led changes (and step_pulse high) on the edge after the ce_tick cycle that carries scnt==PERIOD_TICKS-1, i.e. DIV·PERIOD_TICKS+1 cycles after reset release.
- Load: led = ld_data in the cycle after the handshake edge; next step exactly DIV·PERIOD_TICKS cycles later (±pcnt phase, ≤DIV-1).
- Button: LED off DEB_CYCLES+3 cycles after stable sys_set_n low (2 sync + debounce + FSM).
- Reset asserted mid-operation: all state returns to reset values immediately (async); pending load dropped.

## Structure
- Package led_pkg: LED_W=6, INIT_PAT default, state enum {RUN, FORCE}, rotate function.
- Sub-module led_debounce (synchronizer + stability counter, parameter DEB_CYCLES, output set_act); instantiated once. Prescaler, step timer, FSM stay in top.

## Test plan
Use DIV=4, PERIOD_TICKS=3, DEB_CYCLES=8, INIT_PAT=011111.
- Reset release, dir=0, no inputs → led 011111; step_pulse on cycle 13, led 101111; cycle 25 led 110111; ce_tick every 4 cycles.
- dir=1 from reset → first step led 111110, then 111101.
- ld_valid with ld_data=6'b000011 coincident with a step_req → ld_ready=1, led 000011 next cycle, no step_pulse; next step 12 cycles later → 100001.
- sys_set_n low with 3-cycle bounce then stable → led 000000 exactly 11 cycles after stable low; ld_ready=0; ld_valid held high not accepted; release stable 8+ cycles → led 011111, ld_ready=1.
- sys_rst_n pulsed low mid-load (ld_valid=1) → led 011111, ld_ready=0 during reset, ld_ready=1 on first clock after release, load then accepted.
- Single-cycle sys_set_n glitch (<8 cycles) → led unaffected, stepping continues on schedule.
